// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative encryption core.
// Provides the FSM state type, round-constant lookup, GF(2^8) helpers
// and byte-level helpers for 128-bit blocks (byte 0 = bits [127:120]).
package aes_pkg;

    typedef enum logic [1:0] {StLoad, StRound, StDone} aes_fsm_e;

    localparam logic [3:0] LastRound = 4'd10;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        rc = 8'h00;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, a0 in bits [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int unsigned idx);
        return blk[8*(15-idx) +: 8];
    endfunction

    function automatic logic [127:0] set_byte(input logic [127:0] blk, input int unsigned idx,
                                              input logic [7:0] val);
        logic [127:0] res;
        res = blk;
        res[8*(15-idx) +: 8] = val;
        return res;
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                res = set_byte(res, r + 4*c, get_byte(blk, r + 4*((c + r) % 4)));
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = mix_column(blk[127-32*c -: 32]);
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports: in_byte (8) - byte to substitute; out_byte (8) - substituted byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] s;

    always_comb begin
        s = 8'h00;
        case (in_byte)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end

    assign out_byte = s;

endmodule

// File: rtl/aes_main.sv
// Free-running iterative AES-128 encryption core, one round per clock.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-high reset
//   i_block      - 128-bit plaintext, sampled in LOAD only
//   init_key     - 128-bit cipher key, sampled in LOAD only
//   o_block      - registered ciphertext, updated once per block
//   block_finish - one-cycle pulse coincident with each o_block update
module aes_main
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] i_block,
    input  logic [127:0] init_key,
    output logic [127:0] o_block,
    output logic         block_finish
);

    aes_fsm_e     fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;

    logic [127:0] sub_out;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [127:0] rk_next;
    logic [127:0] round_out;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .in_byte  (state_q[8*i +: 8]),
            .out_byte (sub_out[8*i +: 8])
        );
    end

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*j +: 8]),
            .out_byte (sub_w[8*j +: 8])
        );
    end

    always_comb begin
        logic [31:0]  temp;
        logic [31:0]  w0, w1, w2, w3;
        logic [127:0] shifted;
        logic [127:0] mixed;
        temp    = sub_w ^ {rcon(rnd_q), 24'h0};
        w0      = rk_q[127:96] ^ temp;
        w1      = rk_q[95:64] ^ w0;
        w2      = rk_q[63:32] ^ w1;
        w3      = rk_q[31:0] ^ w2;
        rk_next = {w0, w1, w2, w3};
        shifted = shift_rows(sub_out);
        // Final round omits MixColumns.
        mixed     = (rnd_q == LastRound) ? shifted : mix_columns(shifted);
        round_out = mixed ^ rk_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= StLoad;
            rnd_q        <= 4'd0;
            state_q      <= '0;
            rk_q         <= '0;
            o_block      <= '0;
            block_finish <= 1'b0;
        end else begin
            case (fsm_q)
                StLoad: begin
                    state_q      <= i_block ^ init_key;
                    rk_q         <= init_key;
                    rnd_q        <= 4'd1;
                    block_finish <= 1'b0;
                    fsm_q        <= StRound;
                end
                StRound: begin
                    state_q <= round_out;
                    rk_q    <= rk_next;
                    rnd_q   <= rnd_q + 4'd1;
                    if (rnd_q == LastRound) begin
                        o_block      <= round_out;
                        block_finish <= 1'b1;
                        fsm_q        <= StDone;
                    end
                end
                StDone: begin
                    block_finish <= 1'b0;
                    fsm_q        <= StLoad;
                end
                default: begin
                    fsm_q <= StLoad;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_main.sv
module tb_aes_main;

    logic         clk;
    logic         reset;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] o_block;
    logic         block_finish;

    int total = 0;
    int bad   = 0;
    int e     = 0;          // rising edges since reset release
    logic [127:0] want_out = '0;
    logic [127:0] pending  = '0;
    logic [7:0]   sb_t [256];

    aes_main dut (
        .clk          (clk),
        .reset        (reset),
        .i_block      (pt),
        .init_key     (key),
        .o_block      (o_block),
        .block_finish (block_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (edge %0d)", tag, got, want, e);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p_in, input logic [127:0] k_in);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = p_in[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k_in[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_t[tmp[31:24]], sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                   ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // One clock: the core samples its inputs every 12th edge and reports 10 edges later.
    task automatic step();
        logic [127:0] pt_s, key_s;
        pt_s  = pt;
        key_s = key;
        @(posedge clk);
        e++;
        if (e % 12 == 1) pending = aes_ref(pt_s, key_s);
        if (e % 12 == 11) want_out = pending;
        @(negedge clk);
        check("finish", {127'h0, block_finish}, {127'h0, (e % 12 == 11)});
        check("o_block", o_block, want_out);
    endtask

    // Called at a falling edge; checks the asynchronous clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_o_block", o_block, 128'h0);
        check("rst_finish", {127'h0, block_finish}, 128'h0);
        e        = 0;
        want_out = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pt    = 128'h00112233445566778899aabbccddeeff;
        key   = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 256; i++) sb_t[i] = sbox_calc(i[7:0]);
        #1;
        check("init_o_block", o_block, 128'h0);
        check("init_finish", {127'h0, block_finish}, 128'h0);
        @(negedge clk);
        check("held_o_block", o_block, 128'h0);
        reset = 1'b0;

        repeat (11) step();
        check("fips_c1", o_block, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("fips_c1_flag", {127'h0, block_finish}, 128'h1);

        pt  = 128'h3243f6a8885a308d313198a2e0370734;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        repeat (12) step();
        check("fips_appb", o_block, 128'h3925841d02dc09fbdc118597196a0b32);

        pt  = 128'h0;
        key = 128'h0;
        repeat (12) step();
        check("all_zero", o_block, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        pt  = 128'h10101010202020203030303040404040;
        key = 128'h11111111222222223333333344444444;
        repeat (200) step();

        // Plaintext change while rounds are in flight.
        while (e % 12 != 4) step();
        pt = {$urandom, $urandom, $urandom, $urandom};
        repeat (24) step();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) pt = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 6) == 0) key = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        // Abort with rnd == 5, then the block restarts from LOAD.
        while (e % 12 != 5) step();
        do_reset();
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        repeat (11) step();
        check("post_reset", o_block, aes_ref(pt, key));
        repeat (13) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
